// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared FSM state type and constants for instruction fetch
`include "define.sv"

package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } fetch_state_t;

    // ADDI x0,x0,0
    localparam logic [`XLEN-1:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [`XLEN-1:0] PC_STEP   = 32'd4;

endpackage

// File: rtl/define.sv
// rtl/define.sv - global architecture width shared by the fetch slice
`ifndef DEFINE_SV
`define DEFINE_SV
`ifndef XLEN
`define XLEN 32
`endif
`endif

// File: rtl/fetch_hold_buf.sv
// rtl/fetch_hold_buf.sv - one-entry instruction/pc holding register
//
// Ports:
//   clk, rst_n      clock and synchronous active-low reset
//   load            capture instr_in/pc_in and mark the entry valid
//   clear           drop the entry (wins over load)
//   instr_in, pc_in word and its PC to capture
//   valid           entry holds a word
//   instr, pc       held word and its PC
`include "define.sv"

module fetch_hold_buf (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             clear,
    input  logic [`XLEN-1:0] instr_in,
    input  logic [`XLEN-1:0] pc_in,
    output logic             valid,
    output logic [`XLEN-1:0] instr,
    output logic [`XLEN-1:0] pc
);

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            valid <= 1'b0;
            instr <= '0;
            pc    <= '0;
        end else if (load) begin
            valid <= 1'b1;
            instr <= instr_in;
            pc    <= pc_in;
        end
    end

endmodule

// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - PC generation, single-outstanding imem fetch, registered output
//
// Optional feature macro: FETCH_MISALIGN_CHECK_EN (adds fetch_misalign output and
// parks fetch on a misaligned redirect; otherwise redirect_pc[1:0] is forced to 0).
//
// Ports:
//   clk, rst_n                      clock and synchronous active-low reset
//   halt                            downstream stall, outputs hold
//   redirect_en, redirect_pc        branch/jump redirect pulse and target
//   imem_req, imem_addr, imem_gnt   request/grant handshake to instruction memory
//   imem_rvalid, imem_rdata         memory response
//   instruction_out, pc_out         registered word and its PC to operand fetch
//   instr_valid                     instruction_out is a real instruction
//   fetch_misalign                  (feature only) last redirect target was misaligned
`include "define.sv"

module instruction_fetch #(
    parameter logic [`XLEN-1:0] RESET_PC  = 32'h0000_0000,
    parameter logic [`XLEN-1:0] NOP_INSTR = fetch_pkg::NOP_INSTR
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             halt,
    input  logic             redirect_en,
    input  logic [`XLEN-1:0] redirect_pc,
    output logic             imem_req,
    output logic [`XLEN-1:0] imem_addr,
    input  logic             imem_gnt,
    input  logic             imem_rvalid,
    input  logic [`XLEN-1:0] imem_rdata,
    output logic [`XLEN-1:0] instruction_out,
    output logic [`XLEN-1:0] pc_out,
    output logic             instr_valid
`ifdef FETCH_MISALIGN_CHECK_EN
    ,
    output logic             fetch_misalign
`endif
);

    import fetch_pkg::*;

    fetch_state_t     state;
    fetch_state_t     state_nxt;
    logic [`XLEN-1:0] pc;
    logic             drop;       // the outstanding response belongs to a flushed fetch
    logic             mis;        // parked on a misaligned redirect target
    logic [`XLEN-1:0] target;
    logic             target_bad;
    logic             gnt_acc;
    logic             rsp;
    logic             present_hold;
    logic             hold_load;
    logic             hold_clear;
    logic             hold_valid;
    logic [`XLEN-1:0] hold_instr;
    logic [`XLEN-1:0] hold_pc;

`ifdef FETCH_MISALIGN_CHECK_EN
    assign target         = redirect_pc;
    assign target_bad     = |redirect_pc[1:0];
    assign fetch_misalign = mis;
`else
    assign target         = redirect_pc & {{(`XLEN-2){1'b1}}, 2'b00};
    assign target_bad     = 1'b0;
`endif

    assign gnt_acc      = imem_req && imem_gnt;
    assign rsp          = (state == WAIT) && imem_rvalid;
    assign present_hold = (state == HOLD) && !halt && hold_valid;
    assign hold_load    = rsp && !drop && halt && !redirect_en;
    assign hold_clear   = redirect_en || present_hold;

    fetch_hold_buf u_hold (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (hold_load),
        .clear    (hold_clear),
        .instr_in (imem_rdata),
        .pc_in    (pc),
        .valid    (hold_valid),
        .instr    (hold_instr),
        .pc       (hold_pc)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; a redirect only changes the path out of WAIT/HOLD,
    // a grant taken in the redirect cycle still moves to WAIT to drain it.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: state_nxt = REQ;
            REQ:  if (gnt_acc) state_nxt = WAIT;
            WAIT: begin
                if (imem_rvalid) begin
                    if (redirect_en || drop || !halt) begin
                        state_nxt = REQ;
                    end else begin
                        state_nxt = HOLD;
                    end
                end
            end
            HOLD: if (redirect_en || !halt) state_nxt = REQ;
            default: state_nxt = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        imem_req = 1'b0;
        if (state == REQ && !mis) begin
            imem_req = 1'b1;
        end
    end

    assign imem_addr = pc;

    // PC, drop tracking and the registered output stage
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc              <= RESET_PC;
            drop            <= 1'b0;
            mis             <= 1'b0;
            instruction_out <= NOP_INSTR;
            pc_out          <= RESET_PC;
            instr_valid     <= 1'b0;
        end else if (redirect_en) begin
            pc              <= target;
            mis             <= target_bad;
            instruction_out <= NOP_INSTR;
            instr_valid     <= 1'b0;
            drop            <= gnt_acc || ((state == WAIT) && !imem_rvalid);
        end else begin
            if (rsp && drop) begin
                drop <= 1'b0;
            end
            if (!halt) begin
                if (rsp && !drop) begin
                    instruction_out <= imem_rdata;
                    pc_out          <= pc;
                    instr_valid     <= 1'b1;
                    pc              <= pc + PC_STEP;
                end else if (present_hold) begin
                    instruction_out <= hold_instr;
                    pc_out          <= hold_pc;
                    instr_valid     <= 1'b1;
                    pc              <= pc + PC_STEP;
                end else begin
                    // one-cycle bubble so downstream never consumes a word twice
                    instruction_out <= NOP_INSTR;
                    instr_valid     <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// tb/tb_instruction_fetch.sv - self-checking bench for instruction_fetch
module tb_instruction_fetch;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst_n;
    logic        halt;
    logic        redirect_en;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] instruction_out;
    logic [31:0] pc_out;
    logic        instr_valid;
`ifdef FETCH_MISALIGN_CHECK_EN
    logic        fetch_misalign;
`endif

    instruction_fetch dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .halt            (halt),
        .redirect_en     (redirect_en),
        .redirect_pc     (redirect_pc),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_gnt        (imem_gnt),
        .imem_rvalid     (imem_rvalid),
        .imem_rdata      (imem_rdata),
        .instruction_out (instruction_out),
        .pc_out          (pc_out),
        .instr_valid     (instr_valid)
`ifdef FETCH_MISALIGN_CHECK_EN
        ,
        .fetch_misalign  (fetch_misalign)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errs = 0;
    int checks = 0;

    // reference model state
    bit          outstanding;
    bit          stale;
    int          wait_cnt;
    logic [31:0] exp_fetch;
    logic [31:0] exp_req;
    logic [31:0] mem_addr;
    logic [31:0] q_pc[$];
    logic [31:0] q_ins[$];
    logic        mdl_valid;
    logic [31:0] mdl_instr;
    logic [31:0] mdl_pc;
    logic        mdl_mis;
    int          pres_cnt;
    int          p_gnt;
    int          max_wait;
    bit          force_rv;

    function automatic logic [31:0] mem(input logic [31:0] a);
        if (a == 32'h0) return 32'h0050_0093;
        if (a == 32'h4) return 32'h00A0_0113;
        return {a[15:0], a[31:16]} ^ 32'h6B8D_2E41;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0; halt = 1'b0; redirect_en = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_imem_req", {31'b0, imem_req}, 32'd0);
        chk("rst_instr_valid", {31'b0, instr_valid}, 32'd0);
        chk("rst_instruction_out", instruction_out, NOP);
        chk("rst_pc_out", pc_out, 32'h0);
`ifdef FETCH_MISALIGN_CHECK_EN
        chk("rst_fetch_misalign", {31'b0, fetch_misalign}, 32'd0);
`endif
        outstanding = 0; stale = 0; wait_cnt = 0;
        q_pc.delete(); q_ins.delete();
        mdl_valid = 1'b0; mdl_instr = NOP; mdl_pc = 32'h0; mdl_mis = 1'b0;
        exp_fetch = 32'h0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // rmode: 0 none, 1 redirect, 2 redirect when requesting, 3 redirect when a word is held
    task automatic step(input bit h, input int rmode, input logic [31:0] tgt);
        bit g, rv, re;
        @(negedge clk);
        g  = imem_req && ($urandom_range(1, 100) <= p_gnt);
        rv = force_rv || (outstanding && wait_cnt == 0);
        re = (rmode == 1) || (rmode == 2 && imem_req) || (rmode == 3 && q_pc.size() > 0);
        imem_gnt    = g;
        imem_rvalid = rv;
        imem_rdata  = outstanding ? mem(mem_addr) : 32'hDEAD_BEEF;
        halt        = h;
        redirect_en = re;
        redirect_pc = tgt;

        if (rv && outstanding) begin
            if (!stale) begin
                q_pc.push_back(exp_req);
                q_ins.push_back(mem(exp_req));
            end
            outstanding = 0;
        end else if (outstanding) begin
            wait_cnt--;
        end
        if (g) begin
            chk("fetch_addr", imem_addr, exp_fetch);
            exp_req     = exp_fetch;
            mem_addr    = imem_addr;
            exp_fetch   = exp_fetch + 32'd4;
            outstanding = 1;
            stale       = 0;
            wait_cnt    = $urandom_range(0, max_wait);
        end
        if (!h) begin
            if (q_pc.size() > 0) begin
                mdl_valid = 1'b1;
                mdl_pc    = q_pc.pop_front();
                mdl_instr = q_ins.pop_front();
                pres_cnt++;
            end else begin
                mdl_valid = 1'b0;
                mdl_instr = NOP;
            end
        end
        if (re) begin
            q_pc.delete(); q_ins.delete();
            mdl_valid = 1'b0;
            mdl_instr = NOP;
`ifdef FETCH_MISALIGN_CHECK_EN
            exp_fetch = tgt;
            mdl_mis   = |tgt[1:0];
`else
            exp_fetch = tgt & 32'hFFFF_FFFC;
`endif
            if (outstanding) stale = 1;
        end

        @(posedge clk);
        #1;
        chk("instr_valid", {31'b0, instr_valid}, {31'b0, mdl_valid});
        chk("instruction_out", instruction_out, mdl_instr);
        if (mdl_valid) chk("pc_out", pc_out, mdl_pc);
        if (outstanding || q_pc.size() > 0 || mdl_mis) chk("no_req", {31'b0, imem_req}, 32'd0);
`ifdef FETCH_MISALIGN_CHECK_EN
        chk("fetch_misalign", {31'b0, fetch_misalign}, {31'b0, mdl_mis});
`endif
    endtask

    initial begin
        rst_n = 1'b0; halt = 1'b0; redirect_en = 1'b0; redirect_pc = '0;
        imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
        force_rv = 0; pres_cnt = 0; mem_addr = '0; exp_req = '0;
        p_gnt = 100; max_wait = 0;

        // immediate grant, response one cycle later
        do_reset();
        step(0, 0, 0);
        step(0, 0, 0);
        chk("first_instr", instruction_out, 32'h0050_0093);
        chk("first_pc", pc_out, 32'h0);
        step(0, 0, 0);
        // halted while the 0x4 response arrives
        step(1, 0, 0);
        step(1, 0, 0);
        step(1, 0, 0);
        chk("halt_keeps_pc", pc_out, 32'h0);
        step(0, 0, 0);
        chk("held_instr", instruction_out, 32'h00A0_0113);
        chk("held_pc", pc_out, 32'h4);
        // redirect in the grant cycle for 0x8
        step(0, 2, 32'h100);
        step(0, 0, 0);
        step(0, 0, 0);
        step(0, 0, 0);
        chk("redirect_pc_out", pc_out, 32'h100);
        // redirect while a word is held under halt
        step(0, 0, 0);
        step(1, 0, 0);
        step(1, 3, 32'h300);
        chk("hold_flush_valid", {31'b0, instr_valid}, 32'd0);
        for (int i = 0; i < 6; i++) step(0, 0, 0);
        // pc wraps past the top of the address space
        step(0, 1, 32'hFFFF_FFFC);
        for (int i = 0; i < 8; i++) step(0, 0, 0);
        // misaligned redirect, then a good one
        step(0, 1, 32'h102);
        for (int i = 0; i < 4; i++) step(0, 0, 0);
        step(0, 1, 32'h200);
        for (int i = 0; i < 6; i++) step(0, 0, 0);

        // reset while a response is outstanding, then a late response
        for (int i = 0; i < 20 && !outstanding; i++) step(0, 0, 0);
        chk("reached_wait", {31'b0, outstanding}, 32'd1);
        do_reset();
        force_rv = 1;
        step(0, 0, 0);
        force_rv = 0;
        for (int i = 0; i < 6; i++) step(0, 0, 0);

        // randomized traffic
        p_gnt = 70; max_wait = 2;
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 3) == 0,
                 ($urandom_range(0, 15) == 0) ? 1 : 0,
                 $urandom() & 32'hFFFF_FFFC);
        end
        chk("progress", {31'b0, pres_cnt > 30}, 32'd1);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
